// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control path: control-word bit positions,
// opcodes and the T-state encoding used by the sequencer and its counter.
package cpu_ctrl_pkg;

  localparam int HLT_B = 15;
  localparam int MI_B  = 14;
  localparam int RI_B  = 13;
  localparam int RO_B  = 12;
  localparam int IO_B  = 11;
  localparam int II_B  = 10;
  localparam int AI_B  = 9;
  localparam int AO_B  = 8;
  localparam int EO_B  = 7;
  localparam int SU_B  = 6;
  localparam int BI_B  = 5;
  localparam int OI_B  = 4;
  localparam int CE_B  = 3;
  localparam int CO_B  = 2;
  localparam int J_B   = 1;
  localparam int FI_B  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

  localparam logic [2:0] T_LAST = 3'd4;

  // Single-bit mask of a 16-bit control word, used to compose decode entries.
  function automatic logic [15:0] cw_bit(input int idx);
    cw_bit = 16'(1) << idx;
  endfunction

endpackage

// File: rtl/tstate_counter.sv
// Mod-5 T-state step counter; holds its value while hold is asserted.
module tstate_counter
  import cpu_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  logic     hold,
  output t_state_e t_state
);

  t_state_e t_state_q;
  t_state_e t_state_d;

  always_comb begin
    t_state_d = t_state_q;
    if (!hold) begin
      if (t_state_q == t_state_e'(T_LAST)) begin
        t_state_d = T0;
      end else begin
        t_state_d = t_state_e'(3'(t_state_q + 3'd1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      t_state_q <= T0;
    end else begin
      t_state_q <= t_state_d;
    end
  end

  assign t_state = t_state_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Micro-sequencer: steps T0..T4 and decodes the IR opcode into the control word.
// Conditional jumps (JC/JZ) are decoded only when CTRL_COND_JUMP_EN is defined.
module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int CW_W = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] ir_opcode,
  input  logic            carry_flag,
  input  logic            zero_flag,
  output logic [CW_W-1:0] ctrl_word,
  output logic [2:0]      t_state,
  output logic            halted
);

  localparam logic [15:0] CW_FETCH0 = cw_bit(CO_B) | cw_bit(MI_B);
  localparam logic [15:0] CW_FETCH1 = cw_bit(RO_B) | cw_bit(II_B) | cw_bit(CE_B);
  localparam logic [15:0] CW_ADDR   = cw_bit(IO_B) | cw_bit(MI_B);
  localparam logic [15:0] CW_JUMP   = cw_bit(IO_B) | cw_bit(J_B);
  localparam logic [15:0] CW_ALU    = cw_bit(EO_B) | cw_bit(AI_B) | cw_bit(FI_B);

  t_state_e         t_state_cur;
  logic             halted_q;
  logic             halted_d;
  logic             hlt_entry;
  logic             hold;
  logic [CW_W-1:0]  cw_dec;

`ifndef CTRL_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = carry_flag ^ zero_flag;
`endif

  // HLT at T2 must also freeze the counter on the same edge that sets halted.
  assign hlt_entry = (t_state_cur == T2) && (ir_opcode == OP_W'(OP_HLT)) && !halted_q;
  assign hold      = halted_q | hlt_entry;
  assign halted_d  = halted_q | hlt_entry;

  tstate_counter u_tstate_counter (
    .clk     (clk),
    .clr     (clr),
    .hold    (hold),
    .t_state (t_state_cur)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    cw_dec = '0;
    if (clr) begin
      cw_dec = '0;
    end else if (halted_q) begin
      cw_dec = CW_W'(cw_bit(HLT_B));
    end else if (t_state_cur == T0) begin
      cw_dec = CW_W'(CW_FETCH0);
    end else if (t_state_cur == T1) begin
      cw_dec = CW_W'(CW_FETCH1);
    end else begin
      // Execute steps; anything not listed stays at zero.
      case (ir_opcode)
        OP_W'(OP_LDA): begin
          if (t_state_cur == T2) cw_dec = CW_W'(CW_ADDR);
          if (t_state_cur == T3) cw_dec = CW_W'(cw_bit(RO_B) | cw_bit(AI_B));
        end
        OP_W'(OP_ADD), OP_W'(OP_SUB): begin
          if (t_state_cur == T2) cw_dec = CW_W'(CW_ADDR);
          if (t_state_cur == T3) cw_dec = CW_W'(cw_bit(RO_B) | cw_bit(BI_B));
          if (t_state_cur == T4) begin
            cw_dec = (ir_opcode == OP_W'(OP_SUB)) ? CW_W'(CW_ALU | cw_bit(SU_B))
                                                  : CW_W'(CW_ALU);
          end
        end
        OP_W'(OP_STA): begin
          if (t_state_cur == T2) cw_dec = CW_W'(CW_ADDR);
          if (t_state_cur == T3) cw_dec = CW_W'(cw_bit(AO_B) | cw_bit(RI_B));
        end
        OP_W'(OP_LDI): begin
          if (t_state_cur == T2) cw_dec = CW_W'(cw_bit(IO_B) | cw_bit(AI_B));
        end
        OP_W'(OP_JMP): begin
          if (t_state_cur == T2) cw_dec = CW_W'(CW_JUMP);
        end
`ifdef CTRL_COND_JUMP_EN
        OP_W'(OP_JC): begin
          if (t_state_cur == T2 && carry_flag) cw_dec = CW_W'(CW_JUMP);
        end
        OP_W'(OP_JZ): begin
          if (t_state_cur == T2 && zero_flag) cw_dec = CW_W'(CW_JUMP);
        end
`endif
        OP_W'(OP_OUT): begin
          if (t_state_cur == T2) cw_dec = CW_W'(cw_bit(AO_B) | cw_bit(OI_B));
        end
        OP_W'(OP_HLT): begin
          if (t_state_cur == T2) cw_dec = CW_W'(cw_bit(HLT_B));
        end
        default: cw_dec = '0;
      endcase
    end
  end

  assign ctrl_word = cw_dec;
  assign t_state   = t_state_cur;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer; expectations follow the
// CTRL_COND_JUMP_EN build option.
module tb_ctrl_sequencer;

  logic        clk;
  logic        clr;
  logic [3:0]  ir_opcode;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] ctrl_word;
  logic [2:0]  t_state;
  logic        halted;

  int checks;
  int errors;

`ifdef CTRL_COND_JUMP_EN
  localparam logic [15:0] JC_TAKEN = 16'h0802;
  localparam logic [15:0] JZ_TAKEN = 16'h0802;
`else
  localparam logic [15:0] JC_TAKEN = 16'h0000;
  localparam logic [15:0] JZ_TAKEN = 16'h0000;
`endif

  ctrl_sequencer #(.OP_W(4), .CW_W(16)) dut (
    .clk        (clk),
    .clr        (clr),
    .ir_opcode  (ir_opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl_word  (ctrl_word),
    .t_state    (t_state),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written decode table, evaluated with carry/zero as given.
  function automatic logic [15:0] expCw(input int op, input int t, input bit c, input bit z);
    logic [15:0] r;
    r = 16'h0000;
    if (t == 0) r = 16'h4004;
    else if (t == 1) r = 16'h1408;
    else begin
      case (op)
        1:  r = (t == 2) ? 16'h4800 : (t == 3) ? 16'h1200 : 16'h0000;
        2:  r = (t == 2) ? 16'h4800 : (t == 3) ? 16'h1020 : 16'h0281;
        3:  r = (t == 2) ? 16'h4800 : (t == 3) ? 16'h1020 : 16'h02C1;
        4:  r = (t == 2) ? 16'h4800 : (t == 3) ? 16'h2100 : 16'h0000;
        5:  r = (t == 2) ? 16'h0A00 : 16'h0000;
        6:  r = (t == 2) ? 16'h0802 : 16'h0000;
        7:  r = (t == 2 && c) ? JC_TAKEN : 16'h0000;
        8:  r = (t == 2 && z) ? JZ_TAKEN : 16'h0000;
        14: r = (t == 2) ? 16'h0110 : 16'h0000;
        15: r = (t == 2) ? 16'h8000 : 16'h0000;
        default: r = 16'h0000;
      endcase
    end
    return r;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c_clr, input logic [3:0] op,
                               input logic c, input logic z);
    clr        = c_clr;
    ir_opcode  = op;
    carry_flag = c;
    zero_flag  = z;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] exp_cw,
                             input logic [2:0] exp_t, input logic exp_h);
    logic [4:0] drivers;
    checks++;
    assert (ctrl_word === exp_cw) else begin
      errors++;
      $error("[TB] FAIL %s ctrl_word got=%h exp=%h", tag, ctrl_word, exp_cw);
    end
    checks++;
    assert (t_state === exp_t) else begin
      errors++;
      $error("[TB] FAIL %s t_state got=%0d exp=%0d", tag, t_state, exp_t);
    end
    checks++;
    assert (halted === exp_h) else begin
      errors++;
      $error("[TB] FAIL %s halted got=%b exp=%b", tag, halted, exp_h);
    end
    drivers = {ctrl_word[2], ctrl_word[12], ctrl_word[11], ctrl_word[8], ctrl_word[7]};
    checks++;
    assert ($onehot0(drivers)) else begin
      errors++;
      $error("[TB] FAIL %s bus_drivers got=%b exp=at-most-one-hot", tag, drivers);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset, then a full ADD instruction and wrap to T0.
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rst_held", 16'h0000, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h2, 1'b0, 1'b0);
    checkOutput("add_t0", 16'h4004, 3'd0, 1'b0);
    nextCycle(); checkOutput("add_t1", 16'h1408, 3'd1, 1'b0);
    nextCycle(); checkOutput("add_t2", 16'h4800, 3'd2, 1'b0);
    nextCycle(); checkOutput("add_t3", 16'h1020, 3'd3, 1'b0);
    nextCycle(); checkOutput("add_t4", 16'h0281, 3'd4, 1'b0);
    nextCycle(); checkOutput("add_wrap", 16'h4004, 3'd0, 1'b0);

    // JC with carry set then clear.
    applyStimulus(1'b0, 4'h7, 1'b1, 1'b0);
    nextCycle(); nextCycle();
    checkOutput("jc_c1_t2", JC_TAKEN, 3'd2, 1'b0);
    nextCycle(); checkOutput("jc_c1_t3", 16'h0000, 3'd3, 1'b0);
    nextCycle(); checkOutput("jc_c1_t4", 16'h0000, 3'd4, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h7, 1'b0, 1'b0);
    nextCycle(); nextCycle();
    checkOutput("jc_c0_t2", 16'h0000, 3'd2, 1'b0);
    nextCycle(); nextCycle(); nextCycle();

    // JZ: flag toggles outside T2 must not matter.
    applyStimulus(1'b0, 4'h8, 1'b0, 1'b1);
    nextCycle(); nextCycle();
    checkOutput("jz_z1_t2", JZ_TAKEN, 3'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h8, 1'b0, 1'b0);
    checkOutput("jz_z0_t3", 16'h0000, 3'd3, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h8, 1'b0, 1'b1);
    checkOutput("jz_z1_t4", 16'h0000, 3'd4, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h8, 1'b0, 1'b0);
    nextCycle(); nextCycle();
    checkOutput("jz_z0_t2", 16'h0000, 3'd2, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h8, 1'b0, 1'b1);
    checkOutput("jz_late_t3", 16'h0000, 3'd3, 1'b0);
    nextCycle(); checkOutput("jz_late_t4", 16'h0000, 3'd4, 1'b0);
    nextCycle();

    // Opcode sweep (HLT exercised separately below).
    for (int op = 0; op < 15; op++) begin
      applyStimulus(1'b0, 4'(op), 1'b1, 1'b0);
      for (int t = 0; t < 5; t++) begin
        checkOutput($sformatf("sweep_op%0h_t%0d", op, t), expCw(op, t, 1'b1, 1'b0),
                    3'(t), 1'b0);
        nextCycle();
      end
    end

    // clr during T3 of LDA aborts the instruction.
    applyStimulus(1'b0, 4'h1, 1'b0, 1'b0);
    checkOutput("lda_t0", 16'h4004, 3'd0, 1'b0);
    nextCycle(); nextCycle();
    checkOutput("lda_t2", 16'h4800, 3'd2, 1'b0);
    nextCycle(); checkOutput("lda_t3", 16'h1200, 3'd3, 1'b0);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    checkOutput("lda_clr_comb", 16'h0000, 3'd3, 1'b0);
    nextCycle(); checkOutput("lda_clr_edge", 16'h0000, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b0, 1'b0);
    checkOutput("lda_rel_t0", 16'h4004, 3'd0, 1'b0);
    nextCycle(); checkOutput("lda_rel_t1", 16'h1408, 3'd1, 1'b0);
    nextCycle(); nextCycle(); nextCycle(); nextCycle();

    // HLT: enter halt, stay frozen, leave only via clr.
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
    checkOutput("hlt_t0", 16'h4004, 3'd0, 1'b0);
    nextCycle(); nextCycle();
    checkOutput("hlt_t2", 16'h8000, 3'd2, 1'b0);
    nextCycle(); checkOutput("hlt_enter", 16'h8000, 3'd2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 4'h2, i[0], ~i[0]);
      checkOutput($sformatf("hlt_hold%0d", i), 16'h8000, 3'd2, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    checkOutput("hlt_clr_comb", 16'h0000, 3'd2, 1'b1);
    nextCycle(); checkOutput("hlt_clr_edge", 16'h0000, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h2, 1'b0, 1'b0);
    checkOutput("hlt_rel_t0", 16'h4004, 3'd0, 1'b0);

    // clr on the same edge that would enter halt wins.
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
    nextCycle(); nextCycle();
    checkOutput("race_t2", 16'h8000, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    nextCycle(); checkOutput("race_edge", 16'h0000, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
    checkOutput("race_rel_t0", 16'h4004, 3'd0, 1'b0);
    nextCycle(); checkOutput("race_rel_t1", 16'h1408, 3'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

- Micro-sequencer for the 8-bit bus CPU.
- Steps a five-state T-state counter and decodes the 4-bit opcode from the instruction register into a 16-bit control word. That word drives the write/read enables (`wr_en`, `rd_en`) of every bus register, plus the ALU, PC, RAM and output-port strobes.
- Sits directly upstream of the A/B/IR/MAR/output registers and is the sole source of their enables.

## Interface
- `OP_W`, 4: opcode width (upper nibble of IR).
- `CW_W`, 16: control word width.
- `clk`  in  1: single clock, rising edge.
- `clr`  in  1: reset, synchronous and active-high.
- `ir_opcode`  in  OP_W: IR upper nibble; valid from T2.
- `carry_flag`  in  1: registered ALU carry.
- `zero_flag`  in  1: registered ALU zero.
- `ctrl_word`  out  CW_W: control strobes.
  - Bit 15 hlt, 14 mi, 13 ri, 12 ro, 11 io, 10 ii.
  - Bit 9 ai, 8 ao, 7 eo, 6 su, 5 bi.
  - Bit 4 oi, 3 ce, 2 co, 1 j, 0 fi.
- `t_state`  out  3: current step, 0-4.
- `halted`  out  1: CPU stopped.

## Operation
- `ctrl_word` is combinational from the registered `t_state`/`halted`, `ir_opcode` and the flags. It is forced to 0x0000 while `clr` is high.
- Fetch is common to all opcodes:
  - T0: co|mi = 0x4004.
  - T1: ro|ii|ce = 0x1408.
- Execute steps T2-T4 per opcode (unlisted steps are 0x0000):
  - 0x0 NOP: none.
  - 0x1 LDA: T2 io|mi 0x4800; T3 ro|ai 0x1200.
  - 0x2 ADD: T2 0x4800; T3 ro|bi 0x1020; T4 eo|ai|fi 0x0281.
  - 0x3 SUB: as ADD, but T4 adds su, giving 0x02C1.
  - 0x4 STA: T2 0x4800; T3 ao|ri 0x2100.
  - 0x5 LDI: T2 io|ai 0x0A00.
  - 0x6 JMP: T2 io|j 0x0802.
  - 0x7 JC: T2 0x0802 if `carry_flag`, else 0x0000.
  - 0x8 JZ: T2 0x0802 if `zero_flag`, else 0x0000.
  - 0xE OUT: T2 ao|oi 0x0110.
  - 0xF HLT: T2 hlt 0x8000.
  - 0x9-0xD: treated as NOP.
- Halt behaviour:
  - At the edge ending T2 of HLT, `halted` is set to 1.
  - While halted: `t_state` freezes at 2, `ctrl_word` = 0x8000 and the flags are ignored.
  - Only `clr` exits halt.
- At most one bus driver (co, ro, io, ao, eo) is ever active in any step. Bench asserts this.

## Timing
- Reset:
  - After the `clr` edge: `t_state`=0, `halted`=0, `ctrl_word`=0x4004 once `clr` drops.
  - `clr` mid-instruction aborts it. The next cycle after release is T0.
- Counter:
  - `t_state` advances 0→1→2→3→4→0, one step per clock.
  - Every instruction takes exactly 5 cycles (no early end).
- Decode latency:
  - Zero cycles: `ctrl_word` reflects the current `t_state`.
  - The consumer register latches on the same rising edge that ends the step.
- Flags are sampled combinationally during T2 only. A flag change in any other step has no effect.
- `clr` and HLT-at-T2 on the same edge: `clr` wins, `halted`=0.

## Configuration
- `CTRL_COND_JUMP_EN` defined: JC/JZ decode as above.
- `CTRL_COND_JUMP_EN` undefined:
  - Opcodes 0x7/0x8 decode as NOP.
  - `carry_flag`/`zero_flag` are unused (ports kept).
  - `ctrl_word` bit j is asserted only by JMP.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - Control-bit index constants (HLT_B..FI_B).
  - Opcode constants (OP_NOP..OP_HLT).
  - The T-state enum (T0..T4) and `T_LAST`=4.
- Sub-module `tstate_counter`:
  - Ports `clk`, `clr`, `hold`, `t_state`.
  - Mod-5 counter that freezes while `hold`=1.
  - `ctrl_sequencer` drives `hold` from `halted`.
- Decode is a single case statement in `ctrl_sequencer`.

## Test plan
- Reset, then release `clr`, with `ir_opcode`=0x2 → `ctrl_word` over 5 cycles = 0x4004, 0x1408, 0x4800, 0x1020, 0x0281; then T0 again (0x4004).
- `ir_opcode`=0x7 with `CTRL_COND_JUMP_EN` defined: `carry_flag`=1 → T2 = 0x0802; `carry_flag`=0 → T2 = 0x0000. Without the macro → 0x0000 in both cases.
- `ir_opcode`=0xF → T2 = 0x8000; next edge sets `halted`=1. `t_state` stays 2 and `ctrl_word` stays 0x8000 for 20 cycles. `clr` → `t_state`=0, `halted`=0.
- Assert `clr` during T3 of LDA → `ctrl_word` = 0x0000 while `clr` is high. The first cycle after release is T0 = 0x4004.
- Sweep all 16 opcodes → `ctrl_word` matches the table. Undefined opcodes give 0x0000 in T2-T4. One-hot bus-driver check passes every cycle.
- Toggle `zero_flag` during T3/T4 of JZ → no effect; only the T2 value selects 0x0802 vs 0x0000.
